// File: rtl/i2c_arbiter.sv
// Two-port round-robin arbiter and transaction sequencer for the shared I2C engine.
// Port 0 is the Wishbone register front end; port 1 is the LCD refresh logic.
module i2c_arbiter #(
    parameter int unsigned TIMEOUT = 200000,
    parameter int unsigned CW      = 18
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    output logic        req0_done,
    output logic        req0_err,
    output logic [7:0]  req0_rdata,

    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        req1_done,
    output logic        req1_err,
    output logic [7:0]  req1_rdata,

    output logic [1:0]  eng_rw,
    output logic [31:0] eng_data,
    output logic        eng_startwrite,
    output logic        eng_startread,
    output logic        eng_startwrite_lcd,
    input  logic        eng_busyW,
    input  logic        eng_busyR,
    input  logic        eng_doneW,
    input  logic        eng_doneR,
    input  logic [7:0]  eng_rdata,

    output logic        owner,
    output logic        active
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_LCD = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    logic [1:0]    r_state;
    logic [1:0]    r_op;
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          r_doneW_prev;
    logic          r_doneR_prev;
    logic [1:0]    r_eng_rw;
    logic [31:0]   r_eng_data;
    logic [7:0]    r_rdata0;
    logic [7:0]    r_rdata1;

    logic          w_eng_idle;
    logic          w_gnt;
    logic          w_accept;
    logic [1:0]    w_op;
    logic [31:0]   w_data;
    logic          w_is_rd;
    logic          w_busy;
    logic          w_done_edge;
    logic [CW-1:0] w_cnt_inc;
    logic          w_timeout;

    assign w_eng_idle = ~(eng_busyW | eng_busyR);
    // On a tie the port that did not win last time is granted; otherwise the lone requester.
    assign w_gnt      = (req0_valid & req1_valid) ? ~r_owner : req1_valid;
    assign w_accept   = (r_state == S_IDLE) & w_eng_idle & (req0_valid | req1_valid);
    assign w_op       = w_gnt ? req1_op : req0_op;
    assign w_data     = w_gnt ? req1_data : req0_data;

    assign w_is_rd     = (r_op == OP_RD);
    assign w_busy      = w_is_rd ? eng_busyR : eng_busyW;
    // Only a fresh 0->1 edge counts, so a done level left from the last transaction is ignored.
    assign w_done_edge = w_is_rd ? (eng_doneR & ~r_doneR_prev) : (eng_doneW & ~r_doneW_prev);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_timeout   = (w_cnt_inc == CW'(TIMEOUT));

    assign req0_ready = w_accept & ~w_gnt;
    assign req1_ready = w_accept & w_gnt;

    assign req0_done  = (r_state == S_DONE) & ~r_owner;
    assign req1_done  = (r_state == S_DONE) & r_owner;
    assign req0_err   = req0_done & r_err;
    assign req1_err   = req1_done & r_err;
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;

    assign eng_rw             = r_eng_rw;
    assign eng_data           = r_eng_data;
    assign eng_startwrite     = (r_state == S_START) & (r_op == OP_WR);
    assign eng_startread      = (r_state == S_START) & (r_op == OP_RD);
    assign eng_startwrite_lcd = (r_state == S_START) & (r_op == OP_LCD);

    assign owner  = r_owner;
    assign active = (r_state != S_IDLE);

    // Previous done levels for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_doneW_prev <= 1'b0;
            r_doneR_prev <= 1'b0;
        end else begin
            r_doneW_prev <= eng_doneW;
            r_doneR_prev <= eng_doneR;
        end
    end

    // Transaction sequencer: grant, start handshake, completion wait, done pulse, timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= OP_WR;
            r_owner    <= 1'b1;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_eng_rw   <= 2'b00;
            r_eng_data <= 32'h0;
            r_rdata0   <= 8'h00;
            r_rdata1   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_op;
                        r_eng_rw   <= w_op;
                        r_eng_data <= w_data;
                        r_owner    <= w_gnt;
                        r_cnt      <= '0;
                        r_err      <= (w_op == OP_ILL);
                        r_state    <= (w_op == OP_ILL) ? S_DONE : S_START;
                    end
                end
                S_START: begin
                    if (w_busy) begin
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RUN: begin
                    if (w_done_edge) begin
                        if (w_is_rd) begin
                            if (r_owner) begin
                                r_rdata1 <= eng_rdata;
                            end else begin
                                r_rdata0 <= eng_rdata;
                            end
                        end
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
